// File: rtl/counter_segments_multi_pkg.sv
// Shared constants for the multi-digit counter: active-high 7-segment glyphs
// (bit 0 = A ... bit 6 = G) and the per-radix digit limits.
package counter_segments_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] HEX_MAX = 4'd15;

  function automatic logic [6:0] seg_lookup(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/counter_segments_multi_if.sv
// Bundle of the counter's strobes and display outputs, with a master side
// (debounce filters) and a slave side (the counter itself).
interface counter_segments_multi_if #(
  parameter int NUM_DIGITS = 2
) ();
  logic                    inc;
  logic                    dec;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] count;
  logic [7*NUM_DIGITS-1:0] segments;
  logic                    wrap;

  modport master (output inc, dec, clear, input  count, segments, wrap);
  modport slave  (input  inc, dec, clear, output count, segments, wrap);
endinterface

// File: rtl/counter_segments_multi_decoder.sv
// Combinational digit-to-glyph decoder (active-high). In BCD mode the
// unreachable values 10-15 render blank, as does an asserted blank flag.
module seven_seg_decoder
  import counter_segments_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    if (i_blank || (HEX_MODE == 0 && i_digit > BCD_MAX)) o_seg = SEG_BLANK;
    else                                                  o_seg = seg_lookup(i_digit);
  end

endmodule

// File: rtl/counter_segments_multi.sv
// N-digit BCD/hex up/down counter with registered 7-segment outputs.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module counter_segments_multi
  import counter_segments_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int HEX_MODE   = 0,
  parameter int SATURATE   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Inc,
  input  logic                    i_Dec,
  input  logic                    i_Clear,
  output logic [4*NUM_DIGITS-1:0] o_Count,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam int         CW        = 4 * NUM_DIGITS;
  localparam int         SW        = 7 * NUM_DIGITS;
  localparam logic [3:0] DIGIT_MAX = (HEX_MODE != 0) ? HEX_MAX : BCD_MAX;

  function automatic logic [SW-1:0] reset_segments();
    logic [SW-1:0] s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      s[7*k +: 7] = (k == 0) ? SEG_0 : SEG_BLANK;
`else
      s[7*k +: 7] = SEG_0;
`endif
    end
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  localparam logic [SW-1:0] SEG_RESET = reset_segments();

  logic [CW-1:0]         count_q, count_d, stepped;
  logic                  inc_prev_q, dec_prev_q;
  logic                  wrap_pend_q, wrap_pend_d;
  logic                  wrap_q;
  logic [SW-1:0]         seg_q, seg_d, dec_seg;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            digit;
  logic                  carry;
  logic                  inc_evt, dec_evt;

  assign inc_evt = i_Inc & ~inc_prev_q;
  assign dec_evt = i_Dec & ~dec_prev_q;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d     = count_q;
    wrap_pend_d = 1'b0;
    stepped     = count_q;
    carry       = 1'b1;
    digit       = '0;
    if (i_Clear) begin
      count_d = '0;
    end else if (inc_evt ^ dec_evt) begin
      // Ripple: a digit moves only while every lower digit rolled over.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit = count_q[4*k +: 4];
        if (carry) begin
          if (inc_evt) begin
            if (digit == DIGIT_MAX) stepped[4*k +: 4] = 4'd0;
            else begin
              stepped[4*k +: 4] = digit + 4'd1;
              carry             = 1'b0;
            end
          end else begin
            if (digit == 4'd0) stepped[4*k +: 4] = DIGIT_MAX;
            else begin
              stepped[4*k +: 4] = digit - 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
      wrap_pend_d = carry;
      count_d     = (carry && SATURATE != 0) ? count_q : stepped;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && (count_q[4*k +: 4] == 4'd0);
      blank[k]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seven_seg_decoder #(.HEX_MODE(HEX_MODE)) u_dec (
      .i_digit (count_q[4*g +: 4]),
      .i_blank (blank[g]),
      .o_seg   (dec_seg[7*g +: 7])
    );
  end

  assign seg_d = (ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count_q     <= '0;
      // Tracking the inputs during reset stops a level already high at release from counting.
      inc_prev_q  <= i_Inc;
      dec_prev_q  <= i_Dec;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
      seg_q       <= SEG_RESET;
    end else begin
      count_q     <= count_d;
      inc_prev_q  <= i_Inc;
      dec_prev_q  <= i_Dec;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_pend_q;
      seg_q       <= seg_d;
    end
  end

  assign o_Count    = count_q;
  assign o_Segments = seg_q;
  assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_counter_segments_multi.sv
// Random plus directed bench for counter_segments_multi: a BCD/wrap/active-low
// instance and a hex/saturate/active-high instance share the same strobes.
module tb_counter_segments_multi;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_segments_multi_if #(.NUM_DIGITS(2)) bus ();

  logic [7:0]  count_b;
  logic [13:0] seg_b;
  logic        wrap_b;

  counter_segments_multi #(.NUM_DIGITS(2), .HEX_MODE(0), .SATURATE(0), .ACTIVE_LOW(1)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Inc(bus.inc), .i_Dec(bus.dec), .i_Clear(bus.clear),
    .o_Count(bus.count), .o_Segments(bus.segments), .o_Wrap(bus.wrap)
  );

  counter_segments_multi #(.NUM_DIGITS(2), .HEX_MODE(1), .SATURATE(1), .ACTIVE_LOW(0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Inc(bus.inc), .i_Dec(bus.dec), .i_Clear(bus.clear),
    .o_Count(count_b), .o_Segments(seg_b), .o_Wrap(wrap_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the count is a plain integer modulo base^2, displayed digit by digit.
  typedef struct {
    int cnt;
    int cnt_dly;
    bit wp;
    bit wrap_out;
  } mdl_t;

  mdl_t ma, mb;
  bit   prev_inc, prev_dec;

  function automatic mdl_t mdl_step(mdl_t m, int base, bit sat, bit ie, bit de, bit clr);
    int lim = base * base - 1;
    m.cnt_dly  = m.cnt;
    m.wrap_out = m.wp;
    m.wp       = 1'b0;
    if (clr) m.cnt = 0;
    else if (ie && !de) begin
      if (m.cnt == lim) begin m.wp = 1'b1; if (!sat) m.cnt = 0; end
      else m.cnt++;
    end else if (de && !ie) begin
      if (m.cnt == 0) begin m.wp = 1'b1; if (!sat) m.cnt = lim; end
      else m.cnt--;
    end
    return m;
  endfunction

  function automatic logic [7:0] to_digits(int v, int base);
    logic [7:0] r;
    int p = 1;
    for (int k = 0; k < 2; k++) begin
      r[4*k +: 4] = 4'((v / p) % base);
      p *= base;
    end
    return r;
  endfunction

  function automatic logic [13:0] show(int v, int base, bit al);
    logic [13:0] r;
    logic [6:0]  pat;
    int p = 1;
    for (int k = 0; k < 2; k++) begin
      pat = SEG_TAB[(v / p) % base];
      if (BLK && k > 0 && v < p) pat = 7'h00;
      r[7*k +: 7] = al ? ~pat : pat;
      p *= base;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = mdl_step(ma, 10, 1'b0, bus.inc & ~prev_inc, bus.dec & ~prev_dec, bus.clear);
      mb = mdl_step(mb, 16, 1'b1, bus.inc & ~prev_inc, bus.dec & ~prev_dec, bus.clear);
    end
    prev_inc = bus.inc;
    prev_dec = bus.dec;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_count", bus.count,    to_digits(ma.cnt, 10));
      check("a_seg",   bus.segments, show(ma.cnt_dly, 10, 1'b1));
      check("a_wrap",  bus.wrap,     ma.wrap_out);
      check("b_count", count_b,      to_digits(mb.cnt, 16));
      check("b_seg",   seg_b,        show(mb.cnt_dly, 16, 1'b0));
      check("b_wrap",  wrap_b,       mb.wrap_out);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_inc(input int n = 1);
    repeat (n) begin
      bus.inc = 1'b1; tick();
      bus.inc = 1'b0; tick();
    end
  endtask

  task automatic pulse_dec();
    bus.dec = 1'b1; tick();
    bus.dec = 1'b0; tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; tick();
    bus.clear = 1'b0; tick();
  endtask

  initial begin
    bus.inc = 1'b1; bus.dec = 1'b0; bus.clear = 1'b0;
    tick(2);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(3);
    check("lit_held_at_release", bus.count, 8'h00);
    bus.inc = 1'b0;
    tick();

    pulse_inc();
    check("lit_count_01", bus.count, 8'h01);
    check("lit_seg_01", bus.segments, BLK ? {7'h7F, 7'h79} : {7'h40, 7'h79});
    pulse_inc(9);
    check("lit_seg_10", bus.segments, {7'h79, 7'h40});
    pulse_inc(89);
    check("lit_a_99", bus.count, 8'h99);
    check("lit_b_63", count_b, 8'h63);

    bus.inc = 1'b1; tick();
    check("lit_wrap_count", bus.count, 8'h00);
    check("lit_wrap_early", bus.wrap, 1'b0);
    bus.inc = 1'b0; tick();
    check("lit_wrap_pulse", bus.wrap, 1'b1);
    check("lit_wrap_seg", bus.segments, BLK ? {7'h7F, 7'h40} : {7'h40, 7'h40});
    tick();
    check("lit_wrap_end", bus.wrap, 1'b0);

    pulse_dec();
    check("lit_dec_00", bus.count, 8'h99);

    do_clear();
    pulse_dec();
    check("lit_a_under", bus.count, 8'h99);
    check("lit_a_under_wrap", bus.wrap, 1'b1);
    check("lit_b_sat_low", count_b, 8'h00);
    check("lit_b_sat_low_wrap", wrap_b, 1'b1);

    do_clear();
    pulse_inc(10);
    pulse_dec();
    check("lit_a_borrow", bus.count, 8'h09);
    check("lit_b_borrow", count_b, 8'h09);

    do_clear();
    pulse_inc(255);
    check("lit_b_ff", count_b, 8'hFF);
    pulse_inc();
    check("lit_b_sat_high", count_b, 8'hFF);
    check("lit_b_sat_high_wrap", wrap_b, 1'b1);
    check("lit_a_56", bus.count, 8'h56);

    bus.inc = 1'b1; tick(50);
    bus.inc = 1'b0; tick(2);
    check("lit_held_one", bus.count, 8'h57);

    bus.inc = 1'b1; bus.dec = 1'b1; tick();
    bus.inc = 1'b0; bus.dec = 1'b0; tick();
    check("lit_both_count", bus.count, 8'h57);
    check("lit_both_wrap", bus.wrap, 1'b0);

    do_clear();
    pulse_inc(37);
    check("lit_a_37", bus.count, 8'h37);
    bus.inc = 1'b1; rst = 1'b1; tick();
    check("lit_rst_count", bus.count, 8'h00);
    check("lit_rst_seg_a", bus.segments, BLK ? {7'h7F, 7'h40} : {7'h40, 7'h40});
    check("lit_rst_seg_b", seg_b, BLK ? {7'h00, 7'h3F} : {7'h3F, 7'h3F});
    rst = 1'b0; bus.inc = 1'b0; tick();

    pulse_inc(5);
    bus.inc = 1'b1; bus.clear = 1'b1; tick();
    check("lit_clear_inc", bus.count, 8'h00);
    bus.inc = 1'b0; bus.clear = 1'b0; tick();

    for (int i = 0; i < 3000; i++) begin
      bus.inc   = ($urandom_range(0, 2) != 0);
      bus.dec   = ($urandom_range(0, 3) == 0);
      bus.clear = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0; bus.clear = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
